// File: rtl/calc_pkg.sv
// Shared definitions for the calculator port scheduler: command/response codes,
// default datapath width and the per-port request state.
package calc_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] CMD_NONE = 4'd0;
    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_SHL  = 4'd5;
    localparam logic [3:0] CMD_SHR  = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_PEND = 2'd2,
        ST_RESP = 2'd3
    } port_state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational unsigned add/subtract/shift unit shared by all request ports.
// Overflow, underflow and unknown commands all report an error with zero data.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        resp
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, op1} + {1'b0, op2};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result = '0;
        resp   = RESP_ERR;
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    result = sum[DATA_W-1:0];
                    resp   = RESP_OK;
                end
            end
            CMD_SUB: begin
                if (op1 >= op2) begin
                    result = op1 - op2;
                    resp   = RESP_OK;
                end
            end
            CMD_SHL: begin
                result = op1 << op2[4:0];
                resp   = RESP_OK;
            end
            CMD_SHR: begin
                result = op1 >> op2[4:0];
                resp   = RESP_OK;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_port_sched.sv
// Four-port request scheduler sharing one calc_alu. Each port captures a two-cycle
// request, waits in PEND for a round-robin grant and returns a one-cycle response.
module calc_port_sched
    import calc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [0:3]        req1_cmd_in,
    input  logic [0:3]        req2_cmd_in,
    input  logic [0:3]        req3_cmd_in,
    input  logic [0:3]        req4_cmd_in,
    input  logic [0:DATA_W-1] req1_data_in,
    input  logic [0:DATA_W-1] req2_data_in,
    input  logic [0:DATA_W-1] req3_data_in,
    input  logic [0:DATA_W-1] req4_data_in,
    output logic [0:DATA_W-1] out_data1,
    output logic [0:DATA_W-1] out_data2,
    output logic [0:DATA_W-1] out_data3,
    output logic [0:DATA_W-1] out_data4,
    output logic [0:1]        out_resp1,
    output logic [0:1]        out_resp2,
    output logic [0:1]        out_resp3,
    output logic [0:1]        out_resp4
);

    localparam int N_PORTS = 4;

    logic [3:0]        cmd_in   [N_PORTS];
    logic [DATA_W-1:0] data_in  [N_PORTS];
    logic [3:0]        cmd_arr  [N_PORTS];
    logic [DATA_W-1:0] op1_arr  [N_PORTS];
    logic [DATA_W-1:0] op2_arr  [N_PORTS];
    logic [DATA_W-1:0] data_arr [N_PORTS];
    logic [1:0]        resp_arr [N_PORTS];
    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] port_fire;

    logic [1:0]        ptr_q;
    logic              gnt_valid_q;
    logic [1:0]        gnt_idx_q;
    logic              win_valid;
    logic [1:0]        win_idx;

    logic [DATA_W-1:0] alu_result;
    logic [1:0]        alu_resp;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign out_data1 = data_arr[0];
    assign out_data2 = data_arr[1];
    assign out_data3 = data_arr[2];
    assign out_data4 = data_arr[3];
    assign out_resp1 = resp_arr[0];
    assign out_resp2 = resp_arr[1];
    assign out_resp3 = resp_arr[2];
    assign out_resp4 = resp_arr[3];

    // The grant is registered one cycle ahead of the ALU, so the port already
    // holding the grant is kept out of the next arbitration round.
    always_comb begin
        logic [1:0] idx;
        win_valid = 1'b0;
        win_idx   = ptr_q;
        idx       = ptr_q;
        for (int k = 0; k < N_PORTS; k++) begin
            idx = ptr_q + 2'(k);
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= 2'd0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= 2'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            gnt_valid_q <= win_valid;
            if (win_valid) begin
                gnt_idx_q <= win_idx;
                ptr_q     <= win_idx + 2'd1;
            end
        end
    end

    calc_alu #(.DATA_W(DATA_W)) u_alu (
        .cmd    (cmd_arr[gnt_idx_q]),
        .op1    (op1_arr[gnt_idx_q]),
        .op2    (op2_arr[gnt_idx_q]),
        .result (alu_result),
        .resp   (alu_resp)
    );

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        port_state_e       state_q;
        logic [3:0]        cmd_q;
        logic [DATA_W-1:0] op1_q;
        logic [DATA_W-1:0] op2_q;
        logic [DATA_W-1:0] out_data_q;
        logic [1:0]        out_resp_q;

        assign port_fire[i] = gnt_valid_q && (gnt_idx_q == 2'(i));
        assign eligible[i]  = (state_q == ST_PEND) && !port_fire[i];
        assign cmd_arr[i]   = cmd_q;
        assign op1_arr[i]   = op1_q;
        assign op2_arr[i]   = op2_q;
        assign data_arr[i]  = out_data_q;
        assign resp_arr[i]  = out_resp_q;

        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                state_q    <= ST_IDLE;
                cmd_q      <= CMD_NONE;
                op1_q      <= '0;
                op2_q      <= '0;
                out_data_q <= '0;
                out_resp_q <= RESP_NONE;
            end else begin
                out_data_q <= '0;
                out_resp_q <= RESP_NONE;
                case (state_q)
                    ST_IDLE, ST_RESP: begin
                        if (cmd_in[i] != CMD_NONE) begin
                            state_q <= ST_OP2;
                            cmd_q   <= cmd_in[i];
                            op1_q   <= data_in[i];
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_OP2: begin
                        op2_q   <= data_in[i];
                        state_q <= ST_PEND;
                    end
                    ST_PEND: begin
                        if (port_fire[i]) begin
                            state_q    <= ST_RESP;
                            out_data_q <= alu_result;
                            out_resp_q <= alu_resp;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/calc_port_sched.md
# calc_port_sched

Four-requester scheduler that shares a single add/subtract/shift ALU among the four calculator request ports. It captures each port's two-cycle request (command + operand 1, then operand 2) and queues it per port. It grants the ALU to one pending port per cycle, round-robin, and returns a one-cycle response on the requesting port. It sits between the four external request channels and one `calc_alu` instance, replacing per-port ALUs.

## Interface
- `DATA_W`, 32, operand/result width.
- `c_clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `reqN_cmd_in`  in  [0:3]  command, N=1..4; sampled only when port N is IDLE.
- `reqN_data_in`  in  [0:DATA_W-1]  operand 1 in the command cycle, operand 2 in the next cycle.
- `out_dataN`  out  [0:DATA_W-1]  result, valid only while `out_respN`≠0.
- `out_respN`  out  [0:1]  0 none, 1 success, 2 error (overflow/underflow/invalid), 3 never driven.

## Operation
- Command encoding: 0 none, 1 add, 2 subtract, 5 shift left, 6 shift right; every other nonzero code is invalid.
- Per-port FSM states are IDLE, OP2, PEND and RESP.
  - IDLE → OP2 when cmd≠0; latch cmd and operand 1.
  - OP2 → PEND unconditionally; latch `reqN_data_in` as operand 2 and ignore cmd.
  - PEND → RESP when granted.
  - RESP → IDLE after one cycle. If cmd≠0 in RESP, latch it and go directly to OP2.
- Commands presented in OP2 or PEND are ignored; no error is reported. Requesters must wait for a response.
- Arbiter:
  - One grant per cycle among PEND ports.
  - Round-robin pointer resets to port 1. After a grant to port k, port k+1 (mod 4) has highest priority.
  - The pointer does not move when there is no grant.
- ALU arithmetic is unsigned, DATA_W bits:
  - Add: carry-out → resp 2, data 0.
  - Sub: op1 < op2 → resp 2, data 0; op1 = op2 → resp 1, data 0.
  - Shift left/right: logical shift of op1 by op2[DATA_W-5:DATA_W-1] (low 5 bits). Bits shifted out are discarded and the response is always 1.
  - Invalid cmd: arbitrated like a valid command; the ALU returns resp 2, data 0.
- Outputs are registered. In a non-RESP cycle every `out_respN`=0 and `out_dataN`=0.

## Timing
- Reset values: all `out_dataN`=0, `out_respN`=0, all FSMs IDLE, pointer at port 1.
- Reset mid-operation discards captured and pending requests; no late response follows reset release.
- Latency: cmd sampled at edge t, op2 at t+1, PEND from t+2. If granted at t+2, the response is visible after edge t+3 for exactly one cycle.
- Worst-case wait in PEND is 3 extra cycles, so maximum cmd-to-response is 6 cycles.
- Ports are independent. Up to four requests can be in flight, and at most one response completes per cycle.
- Simultaneous events:
  - Response and new command on the same port in the same cycle: the command is accepted.
  - Grants to the other ports are unaffected.

## Structure
- Package `calc_pkg` holds:
  - command codes `CMD_NONE/ADD/SUB/SHL/SHR` and response codes `RESP_NONE/OK/ERR`;
  - default `DATA_W`;
  - the per-port state enum.
- Sub-module `calc_alu` is combinational: cmd, op1, op2 → result, resp. The scheduler registers its outputs into the granted port's output register.
- Port FSM logic is replicated four times with a generate loop. The round-robin arbiter stays inline.

## Test plan
- **Single add:** port1 cmd 1/0x0000_0001, then 0x1FFF_FFFF, others idle → `out_resp1`=1 and `out_data1`=0x2000_0000 at t+3 for one cycle; ports 2–4 stay 0.
- **Errors:**
  - 0xFFFF_FFFF + 1 → resp 2, data 0.
  - 1 − 0xF → resp 2, data 0.
  - cmd 3, then 4 (op 1/1) → resp 2, data 0 each.
- **Full contention:** all ports issue at t (add 1+1, sub 5−3, shl 1<<4, shr 0x80>>3):
  - responses port1@t+3=2, port2@t+4=2, port3@t+5=16, port4@t+6=16;
  - a second round on ports 2 and 3 only is served port2 first, then port3.
- **Idle:** cmd 0 with random data on all ports for 10 cycles → all responses 0, all data 0.
- **Reset during operation:** assert reset with ports 1–3 in PEND → outputs 0 immediately; no response within 10 cycles after release.
- **Back-to-back:** port1 issues a new add (2+3) in its RESP cycle → accepted, with resp 1 and data 5 three cycles later.
